// File: rtl/prog_loader.sv
// prog_loader: bit-serial loader that assembles MSB-first instruction words and
// writes them to program memory at sequential addresses, holding the core in reset meanwhile.
//  state | meaning
//  IDLE  | no session since reset
//  LOAD  | session active, shifting in serial bits, core held in reset
//  DONE  | session ended, core released, results held
module prog_loader #(
  parameter int WORD_W = 14,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_prog_en,
  input  logic              i_bit_valid,
  input  logic              i_sdata,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_core_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int                CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WORD_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [WORD_W-1:0]  r_wr_data;
  logic               r_err;
  logic [ADDR_W:0]    r_word_count;

  logic               w_enter_load;
  logic               w_end_load;
  logic               w_accept;
  logic               w_word_done;
  logic               w_room;
  logic [WORD_W-1:0]  w_next_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (i_prog_en)  w_next_state = S_LOAD;
      S_LOAD:  if (!i_prog_en) w_next_state = S_DONE;
      S_DONE:  if (i_prog_en)  w_next_state = S_LOAD;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_enter_load = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_prog_en;
  assign w_end_load   = (r_state == S_LOAD) && !i_prog_en;
  assign w_accept     = (r_state == S_LOAD) && i_prog_en && i_bit_valid;
  assign w_word_done  = w_accept && (r_bit_cnt == LAST_BIT);
  // The next write address always equals the number of words written so far.
  assign w_room       = (r_word_count < DEPTH_C);
  assign w_next_word  = {r_shift[WORD_W-2:0], i_sdata};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_enter_load) begin
        r_word_count <= '0;
        r_err        <= 1'b0;
        r_bit_cnt    <= '0;
        r_shift      <= '0;
      end else if (w_end_load) begin
        if (r_bit_cnt != '0) r_err <= 1'b1;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_accept) begin
        r_shift <= w_next_word;
        if (w_word_done) begin
          r_bit_cnt <= '0;
          r_wr_data <= w_next_word;
          if (w_room) begin
            r_wr_en      <= 1'b1;
            r_wr_addr    <= r_word_count[ADDR_W-1:0];
            r_word_count <= r_word_count + 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  // A pending write is suppressed in the cycle reset is asserted.
  assign o_wr_en      = r_wr_en & ~i_reset;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_core_reset = i_reset | (r_state == S_LOAD);
  assign o_busy       = (r_state == S_LOAD);
  assign o_done       = (r_state == S_DONE);
  assign o_err        = r_err;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a full-depth and a DEPTH=4 instance share stimulus and are
// compared every cycle against a word-level reference model, plus vector tables and directed sequences.
module tb_prog_loader;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, prog_en = 1'b0, bit_valid = 1'b0, sdata = 1'b0;

  logic       a_wr_en, a_core_reset, a_busy, a_done, a_err;
  logic [7:0] a_wr_addr;
  logic [13:0] a_wr_data;
  logic [8:0] a_word_count;
  logic       b_wr_en, b_core_reset, b_busy, b_done, b_err;
  logic [7:0] b_wr_addr;
  logic [13:0] b_wr_data;
  logic [8:0] b_word_count;

  prog_loader u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_prog_en(prog_en), .i_bit_valid(bit_valid), .i_sdata(sdata),
    .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data), .o_core_reset(a_core_reset),
    .o_busy(a_busy), .o_done(a_done), .o_err(a_err), .o_word_count(a_word_count));

  prog_loader #(.DEPTH(4)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_prog_en(prog_en), .i_bit_valid(bit_valid), .i_sdata(sdata),
    .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data), .o_core_reset(b_core_reset),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_word_count(b_word_count));

  typedef struct {
    int depth; int mode; int nbits; int acc; int cnt; int err; int wr_en; int addr; int data;
  } model_t;

  typedef struct {
    bit rst; bit pe; bit bv; bit sd;
    bit x_wr_en; bit x_busy; bit x_done; bit x_err; bit x_core;
    int x_wc; bit x_chk; int x_addr; int x_data;
  } vec_t;

  model_t ma, mb;
  int n_checks = 0;
  int n_fail = 0;
  int ncyc = 0;
  int nb_wr = 0;
  int wa_cyc[$];
  int wa_addr[$];
  int wa_data[$];
  vec_t tbl[$];

  function automatic model_t mnew(int depth);
    model_t m;
    m.depth = depth; m.mode = M_IDLE; m.nbits = 0; m.acc = 0; m.cnt = 0;
    m.err = 0; m.wr_en = 0; m.addr = 0; m.data = 0;
    return m;
  endfunction

  // Word-level reference: collect bits arithmetically, write while room remains.
  function automatic model_t mstep(model_t m, bit rst, bit pe, bit bv, bit sd);
    model_t n = m;
    n.wr_en = 0;
    if (rst) return mnew(m.depth);
    if (m.mode != M_LOAD) begin
      if (pe) begin
        n.mode = M_LOAD; n.cnt = 0; n.err = 0; n.nbits = 0; n.acc = 0;
      end
    end else if (!pe) begin
      if (m.nbits != 0) n.err = 1;
      n.nbits = 0; n.acc = 0; n.mode = M_DONE;
    end else if (bv) begin
      n.acc = (m.acc * 2 + int'(sd)) % 16384;
      n.nbits = m.nbits + 1;
      if (n.nbits == 14) begin
        n.data = n.acc; n.nbits = 0; n.acc = 0;
        if (m.cnt < m.depth) begin
          n.wr_en = 1; n.addr = m.cnt; n.cnt = m.cnt + 1;
        end else begin
          n.err = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic vec_t mk(bit rst, bit pe, bit bv, bit sd, bit w, bit b, bit d, bit e, bit c,
                              int wc, bit ck, int ad, int da);
    vec_t v;
    v.rst = rst; v.pe = pe; v.bv = bv; v.sd = sd;
    v.x_wr_en = w; v.x_busy = b; v.x_done = d; v.x_err = e; v.x_core = c;
    v.x_wc = wc; v.x_chk = ck; v.x_addr = ad; v.x_data = da;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, ncyc, act, exp);
    end
  endtask

  task automatic check_model(input string tag, input model_t m, input logic wr_en,
                             input logic [7:0] addr, input logic [13:0] data,
                             input logic core, input logic busy, input logic done,
                             input logic err, input logic [8:0] wc);
    chk({tag, "_wr_en"}, int'(wr_en), m.wr_en);
    chk({tag, "_busy"}, int'(busy), int'(m.mode == M_LOAD));
    chk({tag, "_done"}, int'(done), int'(m.mode == M_DONE));
    chk({tag, "_core_reset"}, int'(core), int'(reset || m.mode == M_LOAD));
    chk({tag, "_err"}, int'(err), m.err);
    chk({tag, "_word_count"}, int'(wc), m.cnt);
    chk({tag, "_wr_addr"}, int'(addr), m.addr);
    chk({tag, "_wr_data"}, int'(data), m.data);
  endtask

  // One clock: drive at negedge, check live outputs, step model at posedge, check at next negedge.
  task automatic cyc(input bit rst, input bit pe, input bit bv, input bit sd);
    reset = rst; prog_en = pe; bit_valid = bv; sdata = sd;
    #1;
    chk("a_wr_en_live", int'(a_wr_en), int'(ma.wr_en == 1 && !rst));
    chk("b_wr_en_live", int'(b_wr_en), int'(mb.wr_en == 1 && !rst));
    chk("a_core_reset_live", int'(a_core_reset), int'(rst || ma.mode == M_LOAD));
    @(posedge clk);
    ma = mstep(ma, rst, pe, bv, sd);
    mb = mstep(mb, rst, pe, bv, sd);
    @(negedge clk);
    ncyc++;
    check_model("a", ma, a_wr_en, a_wr_addr, a_wr_data, a_core_reset, a_busy, a_done, a_err, a_word_count);
    check_model("b", mb, b_wr_en, b_wr_addr, b_wr_data, b_core_reset, b_busy, b_done, b_err, b_word_count);
    if (a_wr_en) begin
      wa_cyc.push_back(ncyc); wa_addr.push_back(int'(a_wr_addr)); wa_data.push_back(int'(a_wr_data));
    end
    if (b_wr_en) nb_wr++;
  endtask

  task automatic send_word(input logic [13:0] w);
    for (int i = 13; i >= 0; i--) cyc(1'b0, 1'b1, 1'b1, w[i]);
  endtask

  task automatic clear_log();
    wa_cyc.delete(); wa_addr.delete(); wa_data.delete(); nb_wr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] w1, w2, wv;
    vec_t v;
    w1 = 14'h2A5F;
    w2 = 14'h1357;
    ma = mnew(256);
    mb = mnew(4);

    // single word, new session, prog_en dropped during the write pulse
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,1, 0, 1,0,0));
    tbl.push_back(mk(0,1,0,0, 0,1,0,0,1, 0, 0,0,0));
    for (int i = 0; i < 14; i++)
      tbl.push_back(mk(0,1,1,w1[13-i], (i == 13),1,0,0,1, (i == 13) ? 1 : 0, (i == 13),0,'h2A5F));
    tbl.push_back(mk(0,0,0,0, 0,0,1,0,0, 1, 1,0,'h2A5F));
    tbl.push_back(mk(0,0,1,1, 0,0,1,0,0, 1, 1,0,'h2A5F));
    tbl.push_back(mk(0,1,0,0, 0,1,0,0,1, 0, 1,0,'h2A5F));
    for (int i = 0; i < 14; i++)
      tbl.push_back(mk(0,1,1,w2[13-i], (i == 13),1,0,0,1, (i == 13) ? 1 : 0, (i == 13),0,'h1357));
    tbl.push_back(mk(0,0,1,0, 0,0,1,0,0, 1, 1,0,'h1357));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      cyc(v.rst, v.pe, v.bv, v.sd);
      chk("tbl_wr_en", int'(a_wr_en), int'(v.x_wr_en));
      chk("tbl_busy", int'(a_busy), int'(v.x_busy));
      chk("tbl_done", int'(a_done), int'(v.x_done));
      chk("tbl_err", int'(a_err), int'(v.x_err));
      chk("tbl_core_reset", int'(a_core_reset), int'(v.x_core));
      chk("tbl_word_count", int'(a_word_count), v.x_wc);
      if (v.x_chk) begin
        chk("tbl_wr_addr", int'(a_wr_addr), v.x_addr);
        chk("tbl_wr_data", int'(a_wr_data), v.x_data);
      end
    end

    // three back-to-back words, bit_valid held high
    clear_log();
    cyc(0, 1, 0, 0);
    send_word(14'h0001); send_word(14'h3FFF); send_word(14'h1234);
    cyc(0, 0, 0, 0);
    chk("b2b_nwrites", wa_cyc.size(), 3);
    if (wa_cyc.size() == 3) begin
      chk("b2b_addr0", wa_addr[0], 0); chk("b2b_addr1", wa_addr[1], 1); chk("b2b_addr2", wa_addr[2], 2);
      chk("b2b_data0", wa_data[0], 'h0001); chk("b2b_data1", wa_data[1], 'h3FFF);
      chk("b2b_data2", wa_data[2], 'h1234);
      chk("b2b_gap01", wa_cyc[1] - wa_cyc[0], 14); chk("b2b_gap12", wa_cyc[2] - wa_cyc[1], 14);
    end
    chk("b2b_word_count", int'(a_word_count), 3);

    // 20 bits then prog_en drop: partial word discarded
    clear_log();
    cyc(0, 1, 0, 0);
    send_word(14'h2222);
    wv = 14'h2D;
    for (int i = 5; i >= 0; i--) cyc(0, 1, 1, wv[i]);
    cyc(0, 0, 0, 0);
    chk("partial_nwrites", wa_cyc.size(), 1);
    chk("partial_err", int'(a_err), 1);
    chk("partial_done", int'(a_done), 1);
    chk("partial_word_count", int'(a_word_count), 1);

    // five words into the DEPTH=4 instance
    clear_log();
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) send_word(14'(16'h0AA0 + k));
    cyc(0, 0, 0, 0);
    chk("ovf_b_nwrites", nb_wr, 4);
    chk("ovf_b_word_count", int'(b_word_count), 4);
    chk("ovf_b_err", int'(b_err), 1);
    chk("ovf_b_last_addr", int'(b_wr_addr), 3);
    chk("ovf_a_word_count", int'(a_word_count), 5);
    chk("ovf_a_err", int'(a_err), 0);

    // reset mid-word, reset during a pending write, then a fresh session
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, 1'(i & 1));
    cyc(1, 1, 1, 1);
    chk("rst_busy", int'(a_busy), 0); chk("rst_done", int'(a_done), 0);
    chk("rst_err", int'(a_err), 0); chk("rst_wc", int'(a_word_count), 0);
    chk("rst_wr_data", int'(a_wr_data), 0); chk("rst_wr_addr", int'(a_wr_addr), 0);
    cyc(0, 0, 0, 0);
    chk("rst_core_reset", int'(a_core_reset), 0);
    cyc(0, 1, 0, 0);
    send_word(14'h1111);
    clear_log();
    cyc(1, 0, 0, 0);
    chk("rst_pending_nwrites", wa_cyc.size(), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    send_word(14'h0F0F);
    cyc(0, 0, 0, 0);
    chk("fresh_nwrites", wa_cyc.size(), 1);
    if (wa_cyc.size() == 1) begin
      chk("fresh_addr", wa_addr[0], 0);
      chk("fresh_data", wa_data[0], 'h0F0F);
    end

    // randomized traffic against the model
    begin
      bit pe_r;
      pe_r = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 39) == 0) pe_r = ~pe_r;
        cyc(($urandom_range(0, 299) == 0), pe_r, ($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader; the writing end of the core's program-memory fetch path.
- Receives 14-bit instruction words MSB-first over a bit-serial strobe interface.
- Writes each word into a writable program memory at sequential addresses starting at 0.
- Holds the PIC core in reset while loading and releases it when loading ends.

Parameters:
WORD_W, 14, instruction word width (matches opcode width)
ADDR_W, 8, program address width (matches program counter width)
DEPTH, 256, number of writable program words; must be at most 2**ADDR_W

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
prog_en  input  1  high = loading session active
bit_valid  input  1  one serial bit presented this cycle
sdata  input  1  serial data bit, MSB of each word first
wr_en  output  1  one-cycle program-memory write strobe
wr_addr  output  ADDR_W  write address, valid while wr_en=1
wr_data  output  WORD_W  write data, valid while wr_en=1
core_reset  output  1  reset request to the PIC core
busy  output  1  high while in LOAD
done  output  1  high in DONE state
err  output  1  sticky session error flag
word_count  output  ADDR_W+1  words written in current/last session

Behaviour:
- Reset: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, word_count=0, shift register and bit counter cleared.
- core_reset = reset OR (state==LOAD), computed combinationally.
- Reset asserted mid-session aborts it; no write occurs in the cycle reset is high or after it.
- States: IDLE, LOAD, DONE.
- IDLE -> LOAD when prog_en=1.
- LOAD -> DONE when prog_en=0.
- DONE -> LOAD when prog_en=1.
- DONE holds otherwise.
- On entry to LOAD (edge where state becomes LOAD): next address=0, word_count=0, err=0, bit counter=0, shift register=0.
- In LOAD with prog_en=1 and bit_valid=1:
  - shift register = {shift[WORD_W-2:0], sdata}; bit counter increments.
  - On the edge accepting bit WORD_W, the completed word is latched into wr_data and the bit counter returns to 0.
  - If next address < DEPTH: wr_en=1 for exactly the following cycle with wr_addr = next address; next address and word_count increment at that same edge.
  - If next address >= DEPTH (overflow): no write, err set to 1.
- Write latency: wr_en is high in the cycle immediately after the edge that accepted the last bit of a word.
- bit_valid is accepted in the same cycle wr_en is high; the shift register is independent of wr_data. Back-to-back words with bit_valid held high are supported with no bubbles.
- bit_valid is ignored when prog_en=0 and in IDLE and DONE.
- prog_en falling (LOAD -> DONE edge):
  - A write already scheduled by the previous edge still completes in that cycle.
  - If bit counter != 0, the partial word is discarded and err is set.
- wr_en is 0 in all cycles other than the scheduled write pulse; wr_addr and wr_data hold their last values.
- busy=1 iff state==LOAD; done=1 iff state==DONE.
- word_count saturates naturally at DEPTH because overflowed words are not counted.

Test Plan:
- Reset, then prog_en=1, stream 14 bits of 0x2A5F, prog_en=0. Expect: single wr_en pulse one cycle after bit 14 with wr_addr=0 and wr_data=0x2A5F; word_count=1, done=1, err=0; core_reset=1 throughout LOAD and 0 in DONE.
- Stream 3 words 0x0001, 0x3FFF, 0x1234 with bit_valid held high continuously. Expect: writes at addresses 0, 1, 2 exactly 14 cycles apart with matching data; word_count=3.
- Stream 20 bits then drop prog_en. Expect: one write (addr 0), partial 6 bits discarded, err=1, done=1, word_count=1.
- With DEPTH=4, stream 5 words. Expect: writes to addresses 0–3 only, no fifth wr_en, err=1, word_count=4.
- Assert reset for one cycle mid-word during LOAD. Expect: state IDLE, all outputs 0, no wr_en. A new session then writes its first word to address 0.
- Drop prog_en in the same cycle as the 14th-bit edge-plus-one. Expect: that write still occurs, DONE is entered, err=0.
